// File: rtl/vx_jal_overload_tracker.sv
// Per-core JAL-overload tracker: overrides the first JAL link of each participating
// warp with the return-handler address and queues the original link PC for the IRQ controller.
module vx_jal_overload_tracker #(
  parameter int WARP_CNT  = 4,
  parameter int ISSUE_CNT = 4,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 8,
  parameter int WID_W     = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_arm,
  input  logic                       i_abort,
  input  logic [WARP_CNT-1:0]        i_warp_mask,
  input  logic [XLEN-1:0]            i_ret_handler_addr,
  input  logic [ISSUE_CNT-1:0]       i_slot_valid,
  input  logic [ISSUE_CNT-1:0]       i_slot_ready,
  input  logic [ISSUE_CNT-1:0]       i_slot_is_jal,
  input  logic [ISSUE_CNT*WID_W-1:0] i_slot_wid,
  input  logic [ISSUE_CNT*XLEN-1:0]  i_slot_link,
  output logic [ISSUE_CNT-1:0]       o_slot_override,
  output logic                       o_ret_valid,
  input  logic                       i_ret_ready,
  output logic [WID_W-1:0]           o_ret_wid,
  output logic [XLEN-1:0]            o_ret_pc,
  output logic [WARP_CNT-1:0]        o_hit_mask,
  output logic                       o_busy,
  output logic                       o_all_hit,
  output logic                       o_overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [WARP_CNT-1:0]  r_pend_mask, r_hit_mask;
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic                 r_overflow, r_all_hit;
  logic [WID_W-1:0]     r_mem_wid [DEPTH];
  logic [XLEN-1:0]      r_mem_pc  [DEPTH];

  logic [WID_W-1:0]     w_wid  [ISSUE_CNT];
  logic [XLEN-1:0]      w_link [ISSUE_CNT];
  logic [AW-1:0]        w_wr_addr [ISSUE_CNT];
  logic [ISSUE_CNT-1:0] w_fire, w_cand, w_qual, w_accept, w_reject;
  logic [WARP_CNT-1:0]  w_new_hits;
  logic [PTR_W-1:0]     w_occ, w_free, w_acc_cnt, w_push_cnt;
  logic                 w_pop, w_drain_empty, w_cover, w_done;

  // The substituted value itself is muxed in the commit path; only the select is produced here.
  logic w_unused;
  assign w_unused = ^i_ret_handler_addr;

  assign w_fire        = i_slot_valid & i_slot_ready;
  assign w_occ         = r_wr_ptr - r_rd_ptr;
  assign w_free        = PTR_W'(DEPTH) - w_occ;
  assign o_ret_valid   = (w_occ != '0);
  assign w_pop         = o_ret_valid & i_ret_ready;
  assign o_ret_wid     = r_mem_wid[r_rd_ptr[AW-1:0]];
  assign o_ret_pc      = r_mem_pc[r_rd_ptr[AW-1:0]];
  assign w_drain_empty = (w_occ == '0) || ((w_occ == PTR_W'(1)) && w_pop);
  assign w_cover       = ((r_hit_mask | w_new_hits) & r_pend_mask) == r_pend_mask;
  assign o_hit_mask    = r_hit_mask;
  assign o_overflow    = r_overflow;
  assign o_all_hit     = r_all_hit;

  always_comb begin
    for (int i = 0; i < ISSUE_CNT; i++) begin
      w_wid[i]  = i_slot_wid[i*WID_W +: WID_W];
      w_link[i] = i_slot_link[i*XLEN +: XLEN];
      w_cand[i] = (r_state == S_ARMED) && w_fire[i] && i_slot_is_jal[i] &&
                  r_pend_mask[w_wid[i]] && !r_hit_mask[w_wid[i]];
    end
  end

  // Dedup by warp id (lowest slot wins), then accept in slot order while FIFO space remains.
  // NOTE: blocking assignments in combinational logic; every output gets a default first so no latch is inferred.
  always_comb begin
    w_qual     = '0;
    w_accept   = '0;
    w_reject   = '0;
    w_new_hits = '0;
    w_acc_cnt  = '0;
    for (int i = 0; i < ISSUE_CNT; i++) begin
      w_wr_addr[i] = AW'(r_wr_ptr + w_acc_cnt);
      w_qual[i]    = w_cand[i];
      for (int j = 0; j < i; j++) begin
        if (w_cand[j] && (w_wid[j] == w_wid[i])) w_qual[i] = 1'b0;
      end
      if (w_qual[i]) begin
        if (w_acc_cnt < w_free) begin
          w_accept[i]           = 1'b1;
          w_new_hits[w_wid[i]]  = 1'b1;
          w_acc_cnt             = w_acc_cnt + PTR_W'(1);
        end else begin
          w_reject[i] = 1'b1;
        end
      end
    end
    w_push_cnt = w_acc_cnt;
  end

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state (abort has priority everywhere)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_arm) w_state_nxt = (i_warp_mask != '0) ? S_ARMED : S_DRAIN;
      S_ARMED: if (w_cover) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_empty) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    o_busy          = (r_state != S_IDLE);
    o_slot_override = w_accept;
    w_done          = (r_state == S_DRAIN) && w_drain_empty && !i_abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_mask <= '0;
      r_hit_mask  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_all_hit   <= 1'b0;
    end else begin
      r_all_hit <= w_done;
      if (i_abort) begin
        r_hit_mask <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_overflow <= 1'b0;
      end else if ((r_state == S_IDLE) && i_arm) begin
        r_pend_mask <= i_warp_mask;
        r_hit_mask  <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_overflow  <= 1'b0;
      end else begin
        r_hit_mask <= r_hit_mask | w_new_hits;
        r_wr_ptr   <= r_wr_ptr + w_push_cnt;
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (|w_reject) r_overflow <= 1'b1;
      end
    end
  end

  // NOTE: storage is not reset; entries are only visible through pointers, which are.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_CNT; i++) begin
      if (w_accept[i]) begin
        r_mem_wid[w_wr_addr[i]] <= w_wid[i];
        r_mem_pc[w_wr_addr[i]]  <= w_link[i];
      end
    end
  end

endmodule

// File: doc/vx_jal_overload_tracker.md
Name: vx_jal_overload_tracker

Overview:
- Per-core tracker for the JAL-overload phase of the hardware-interrupt scheduler. While a session is armed, the block watches ALU commit slots.
- On the first JAL committed by each participating warp, it tells the commit path to replace that JAL's link value with the return-handler address. It also queues the original link PC, tagged with its warp id, for the interrupt controller.
- It generalises the earlier fixed per-warp logic in three ways: a configurable participating-warp mask, any warp on any issue slot, and a buffered return-PC queue with backpressure and overflow reporting.

Parameters:
- WARP_CNT, 4, number of warps tracked.
- ISSUE_CNT, 4, number of ALU commit slots observed per cycle.
- XLEN, 32, address width.
- DEPTH, 8, return-PC FIFO entries. Must be a power of 2 and ≥ ISSUE_CNT.
- WID_W, log2up(WARP_CNT), warp-id width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- arm  in  1  start session (pulse)
- abort  in  1  cancel session, flush state
- warp_mask  in  WARP_CNT  participating warps, sampled on arm
- ret_handler_addr  in  XLEN  value substituted into the link register
- slot_valid  in  ISSUE_CNT  commit slot valid
- slot_ready  in  ISSUE_CNT  commit slot ready; fire = valid & ready
- slot_is_jal  in  ISSUE_CNT  committing instruction is JAL with writeback
- slot_wid  in  ISSUE_CNT*WID_W  warp id per slot
- slot_link  in  ISSUE_CNT*XLEN  lane-0 link value per slot
- slot_override  out  ISSUE_CNT  combinational: select ret_handler_addr for this slot's data
- ret_valid  out  1  FIFO head valid
- ret_ready  in  1  consumer accept
- ret_wid  out  WID_W  head warp id
- ret_pc  out  XLEN  head original return PC
- hit_mask  out  WARP_CNT  warps captured this session
- busy  out  1  state != IDLE
- all_hit  out  1  one-cycle pulse at session completion
- overflow  out  1  sticky; cleared by arm, abort or reset

Behaviour:
- Reset: state=IDLE; hit_mask, pend_mask, FIFO pointers, overflow and all_hit are 0. ret_valid=0. slot_override=0.
- States:
  - IDLE: on arm, pend_mask<=warp_mask, hit_mask<=0, overflow<=0, FIFO flushed. Next state is ARMED if warp_mask≠0, else DRAIN.
  - ARMED: capture active. When (hit_mask|new_hits) covers pend_mask, go to DRAIN on the same edge.
  - DRAIN: wait for FIFO empty, including any pop this cycle. Then pulse all_hit and go to IDLE.
  - All states: abort has priority. It forces IDLE, clears hit_mask, flushes the FIFO, and suppresses all_hit.
  - arm while not IDLE is ignored.
- Candidate slot i (ARMED only): fire_i & slot_is_jal_i & pend_mask[wid_i] & !hit_mask[wid_i].
- Same-cycle duplicates: if several candidates share a wid, only the lowest-index slot qualifies.
- Capacity: let free = DEPTH − occupancy, where occupancy is the registered count before this cycle's pop. Qualifying slots are accepted in ascending index order, up to free.
- Rejected qualifiers: no override, no hit recorded, overflow<=1. The warp stays eligible for a later JAL.
- Accepted slot i:
  - slot_override[i]=1 in the same cycle.
  - hit_mask[wid] set at the next edge.
  - Entry {wid, slot_link_i} written in slot-index order. It is visible on ret_* the next cycle.
- FIFO: multi-write (≤ ISSUE_CNT per cycle), single-read, pop on ret_valid & ret_ready. Simultaneous push and pop are allowed. Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. No write ever occurs when full.
- slot_override is 0 in IDLE, in DRAIN, and for non-firing slots.

Test Plan:
1. Reset, then arm with warp_mask=4'b1111. JALs fire on slots 0..3 with wids 0..3, links 0x100,0x104,0x108,0x10C, all in one cycle:
   - slot_override=4'b1111 that cycle.
   - FIFO pops in order (0,0x100)…(3,0x10C).
   - all_hit pulses one cycle after the last pop.
   - busy returns to 0.
2. Armed, warp_mask=4'b0011. Slots 0 and 2 both carry wid 1 JAL, link 0x200/0x300:
   - slot_override=4'b0001.
   - Single entry (1,0x200).
   - A later JAL from wid 1 is not overridden.
3. DEPTH=4, ret_ready=0. Wids 0..3 are captured; a JAL from wid 4 (WARP_CNT=8) arrives with FIFO full:
   - No override, overflow=1, hit_mask[4]=0.
   - After one pop, the next wid 4 JAL is accepted.
4. A JAL with slot_valid=1 and slot_ready=0 for several cycles: slot_override=0 until the ready cycle, then 1 exactly once.
5. Abort mid-ARMED with 2 FIFO entries: next cycle busy=0, ret_valid=0, hit_mask=0; all_hit never pulses.
6. arm with warp_mask=0: ARMED is skipped, and all_hit pulses two cycles after arm. A second arm issued while busy is ignored.
